// File: rtl/l2b_evict_rdma_rd_sched.sv
// Read-port scheduler for the l2b writeback (evict) and RDMA buffers: picks one pending line,
// streams its beats into the l2b read port as the consumer accepts them, then pulses done.
module l2b_evict_rdma_rd_sched #(
  parameter int WB_ENTRIES   = 8,
  parameter int WB_WL_W      = 3,
  parameter int WB_BEATS     = 8,
  parameter int RDMA_ENTRIES = 4,
  parameter int RDMA_WL_W    = 2,
  parameter int RDMA_BEATS   = 4
) (
  input  logic                    gclk,
  input  logic                    rst,
  input  logic [WB_ENTRIES-1:0]   wb_pend,
  input  logic [RDMA_ENTRIES-1:0] rdma_pend,
  input  logic                    mcu_wr_rdy,
  input  logic                    sio_rdy,
  output logic                    l2b_evict_en_r0,
  output logic                    l2b_wbrd_en_r0,
  output logic [WB_WL_W-1:0]      l2b_wbrd_wl_r0,
  output logic [2:0]              l2b_ev_dword_r0,
  output logic                    l2b_rdma_rden_r0,
  output logic [RDMA_WL_W-1:0]    l2b_rdma_rdwl_r0,
  output logic                    wb_done,
  output logic [WB_WL_W-1:0]      wb_done_wl,
  output logic                    rdma_done,
  output logic [RDMA_WL_W-1:0]    rdma_done_wl,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = (WB_BEATS > RDMA_BEATS) ? $clog2(WB_BEATS) : $clog2(RDMA_BEATS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WB_XFER   = 2'd1,
    RDMA_XFER = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [WB_WL_W-1:0]     r_wb_wl;
  logic [WB_WL_W-1:0]     r_wb_ptr;
  logic [WB_WL_W-1:0]     r_wb_done_wl;
  logic [RDMA_WL_W-1:0]   r_rdma_wl;
  logic [RDMA_WL_W-1:0]   r_rdma_ptr;
  logic [RDMA_WL_W-1:0]   r_rdma_done_wl;
  logic                   r_last_class;  // 0: WB granted last, 1: RDMA granted last
  logic                   r_wb_done;
  logic                   r_rdma_done;

  logic [WB_ENTRIES-1:0]   w_wb_elig;
  logic [RDMA_ENTRIES-1:0] w_rdma_elig;
  logic                    w_wb_any;
  logic                    w_rdma_any;
  logic                    w_pick_rdma;
  logic [WB_WL_W-1:0]      w_wb_sel;
  logic [RDMA_WL_W-1:0]    w_rdma_sel;
  logic                    w_wb_beat;
  logic                    w_rdma_beat;

  function automatic logic [WB_WL_W-1:0] wb_rr(input logic [WB_ENTRIES-1:0] req,
                                                input logic [WB_WL_W-1:0] ptr);
    logic               found;
    logic [WB_WL_W-1:0] idx;
    found = 1'b0;
    wb_rr = '0;
    for (int k = 0; k < WB_ENTRIES; k++) begin
      idx = WB_WL_W'((int'(ptr) + k) % WB_ENTRIES);
      if (!found && req[idx]) begin
        found = 1'b1;
        wb_rr = idx;
      end
    end
  endfunction

  function automatic logic [RDMA_WL_W-1:0] rdma_rr(input logic [RDMA_ENTRIES-1:0] req,
                                                    input logic [RDMA_WL_W-1:0] ptr);
    logic                 found;
    logic [RDMA_WL_W-1:0] idx;
    found = 1'b0;
    rdma_rr = '0;
    for (int k = 0; k < RDMA_ENTRIES; k++) begin
      idx = RDMA_WL_W'((int'(ptr) + k) % RDMA_ENTRIES);
      if (!found && req[idx]) begin
        found = 1'b1;
        rdma_rr = idx;
      end
    end
  endfunction

  // The owner drops pend one cycle after done, so mask the entry finishing this cycle.
  always_comb begin
    w_wb_elig   = wb_pend;
    w_rdma_elig = rdma_pend;
    if (r_wb_done)   w_wb_elig[r_wb_done_wl]     = 1'b0;
    if (r_rdma_done) w_rdma_elig[r_rdma_done_wl] = 1'b0;
  end

  assign w_wb_any    = |w_wb_elig;
  assign w_rdma_any  = |w_rdma_elig;
  assign w_pick_rdma = w_rdma_any && (!w_wb_any || !r_last_class);
  assign w_wb_sel    = wb_rr(w_wb_elig, r_wb_ptr);
  assign w_rdma_sel  = rdma_rr(w_rdma_elig, r_rdma_ptr);

  always_ff @(posedge gclk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_wb_wl        <= '0;
      r_wb_ptr       <= '0;
      r_wb_done_wl   <= '0;
      r_rdma_wl      <= '0;
      r_rdma_ptr     <= '0;
      r_rdma_done_wl <= '0;
      r_last_class   <= 1'b0;
      r_wb_done      <= 1'b0;
      r_rdma_done    <= 1'b0;
    end else begin
      r_wb_done      <= 1'b0;
      r_rdma_done    <= 1'b0;
      r_wb_done_wl   <= '0;
      r_rdma_done_wl <= '0;
      case (r_state)
        IDLE: begin
          if (w_wb_any || w_rdma_any) begin
            r_cnt <= '0;
            if (w_pick_rdma) begin
              r_state      <= RDMA_XFER;
              r_rdma_wl    <= w_rdma_sel;
              r_rdma_ptr   <= RDMA_WL_W'((int'(w_rdma_sel) + 1) % RDMA_ENTRIES);
              r_last_class <= 1'b1;
            end else begin
              r_state      <= WB_XFER;
              r_wb_wl      <= w_wb_sel;
              r_wb_ptr     <= WB_WL_W'((int'(w_wb_sel) + 1) % WB_ENTRIES);
              r_last_class <= 1'b0;
            end
          end
        end
        WB_XFER: begin
          if (mcu_wr_rdy) begin
            if (r_cnt == CNT_W'(WB_BEATS - 1)) begin
              r_cnt        <= '0;
              r_state      <= IDLE;
              r_wb_done    <= 1'b1;
              r_wb_done_wl <= r_wb_wl;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        RDMA_XFER: begin
          if (sio_rdy) begin
            if (r_cnt == CNT_W'(RDMA_BEATS - 1)) begin
              r_cnt          <= '0;
              r_state        <= IDLE;
              r_rdma_done    <= 1'b1;
              r_rdma_done_wl <= r_rdma_wl;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A beat issues in the same cycle the consumer signals ready.
  assign w_wb_beat   = (r_state == WB_XFER) && mcu_wr_rdy;
  assign w_rdma_beat = (r_state == RDMA_XFER) && sio_rdy;

  assign l2b_wbrd_en_r0   = w_wb_beat;
  assign l2b_evict_en_r0  = w_wb_beat;
  assign l2b_wbrd_wl_r0   = w_wb_beat ? r_wb_wl : '0;
  assign l2b_ev_dword_r0  = w_wb_beat ? 3'(r_cnt) : 3'd0;
  assign l2b_rdma_rden_r0 = w_rdma_beat;
  assign l2b_rdma_rdwl_r0 = w_rdma_beat ? r_rdma_wl : '0;
  assign wb_done          = r_wb_done;
  assign wb_done_wl       = r_wb_done_wl;
  assign rdma_done        = r_rdma_done;
  assign rdma_done_wl     = r_rdma_done_wl;
  assign busy             = (r_state != IDLE);
  assign dbg_state        = r_state;

endmodule
